// File: rtl/apu_shared_unit_arbiter_pkg.sv
// Shared definitions for the APU shared-unit arbiter: default unit widths/latency
// and the round-robin pointer helper.
package apu_shared_unit_arbiter_pkg;

    localparam int unsigned FP_WIDTH          = 32;
    localparam int unsigned WOP_FP            = 1;
    localparam int unsigned NDSFLAGS_FP       = 3;
    localparam int unsigned NUSFLAGS_FP       = 8;
    localparam int unsigned C_FPADD_PIPE_REGS = 1;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apu_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the priority pointer
// and advances the pointer past each winner.
module apu_rr_arbiter
    import apu_shared_unit_arbiter_pkg::*;
#(
    parameter int unsigned NB_CORES = 4,
    parameter int unsigned IdWidth  = $clog2(NB_CORES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NB_CORES-1:0] req_i,
    output logic [NB_CORES-1:0] gnt_o,
    output logic [IdWidth-1:0]  winner_o,
    output logic                valid_o
);

    logic [IdWidth-1:0] prio_q, prio_d;
    logic [IdWidth-1:0] cand;
    int unsigned        idx;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            idx  = (32'(prio_q) + k) % NB_CORES;
            cand = IdWidth'(idx);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                winner_o    = cand;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (valid_o) begin
            prio_d = IdWidth'(rr_next(32'(winner_o), NB_CORES));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/apu_shared_unit_arbiter.sv
// Shares one fixed-latency pipelined APU unit among NB_CORES cores: round-robin
// issue, core-id tag pipeline, and result routing LATENCY cycles later.
module apu_shared_unit_arbiter
    import apu_shared_unit_arbiter_pkg::*;
#(
    parameter int unsigned NB_CORES = 4,
    parameter int unsigned NARGS    = 2,
    parameter int unsigned WIDTH    = FP_WIDTH,
    parameter int unsigned WOP      = WOP_FP,
    parameter int unsigned NDSFLAGS = NDSFLAGS_FP,
    parameter int unsigned NUSFLAGS = NUSFLAGS_FP,
    parameter int unsigned LATENCY  = C_FPADD_PIPE_REGS
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NB_CORES-1:0]                req_i,
    output logic [NB_CORES-1:0]                gnt_o,
    input  logic [NB_CORES*WOP-1:0]            op_i,
    input  logic [NB_CORES*NARGS*WIDTH-1:0]    operands_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]       flags_i,
    output logic [NB_CORES-1:0]                rvalid_o,
    output logic [WIDTH-1:0]                   result_o,
    output logic [NUSFLAGS-1:0]                flags_o,
    output logic                               unit_en_o,
    output logic [WOP-1:0]                     unit_op_o,
    output logic [NARGS*WIDTH-1:0]             unit_operands_o,
    output logic [NDSFLAGS-1:0]                unit_flags_o,
    input  logic [WIDTH-1:0]                   unit_result_i,
    input  logic [NUSFLAGS-1:0]                unit_flags_i,
    output logic                               busy_o
);

    localparam int unsigned IdWidth = $clog2(NB_CORES);

    logic [IdWidth-1:0]             winner;
    logic                           grant_valid;
    logic [WOP-1:0]                 sel_op, op_q;
    logic [NARGS*WIDTH-1:0]         sel_operands, operands_q;
    logic [NDSFLAGS-1:0]            sel_flags, flags_q;
    logic [LATENCY-1:0]             tag_valid_q;
    logic [LATENCY-1:0][IdWidth-1:0] tag_id_q;

    apu_rr_arbiter #(
        .NB_CORES (NB_CORES),
        .IdWidth  (IdWidth)
    ) u_rr_arbiter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .winner_o (winner),
        .valid_o  (grant_valid)
    );

    always_comb begin
        sel_op       = op_i[32'(winner)*WOP +: WOP];
        sel_operands = operands_i[32'(winner)*NARGS*WIDTH +: NARGS*WIDTH];
        sel_flags    = flags_i[32'(winner)*NDSFLAGS +: NDSFLAGS];
    end

    // Unit inputs hold the last issued operation while idle to avoid toggling.
    assign unit_en_o       = grant_valid;
    assign unit_op_o       = grant_valid ? sel_op       : op_q;
    assign unit_operands_o = grant_valid ? sel_operands : operands_q;
    assign unit_flags_o    = grant_valid ? sel_flags    : flags_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            operands_q <= '0;
            flags_q    <= '0;
        end else if (grant_valid) begin
            op_q       <= sel_op;
            operands_q <= sel_operands;
            flags_q    <= sel_flags;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            tag_valid_q[0] <= grant_valid;
            tag_id_q[0]    <= winner;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
        end
    end

    always_comb begin
        rvalid_o                          = '0;
        rvalid_o[tag_id_q[LATENCY-1]]     = tag_valid_q[LATENCY-1];
    end

    assign result_o = unit_result_i;
    assign flags_o  = unit_flags_i;
    assign busy_o   = |tag_valid_q;

endmodule

// File: tb/tb_apu_shared_unit_arbiter.sv
// Directed bench: four arbiter instances (LATENCY 1, 2, 3, 5), each with a fake
// pipelined unit, checked against hand-computed grant/result schedules.
module tb_apu_shared_unit_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n         [4];
    logic [3:0]   req           [4];
    logic [3:0]   gnt           [4];
    logic [3:0]   op            [4];
    logic [255:0] operands      [4];
    logic [11:0]  flags_in      [4];
    logic [3:0]   rvalid        [4];
    logic [31:0]  result        [4];
    logic [7:0]   flags_out     [4];
    logic         unit_en       [4];
    logic         unit_op       [4];
    logic [63:0]  unit_operands [4];
    logic [2:0]   unit_flags    [4];
    logic [31:0]  unit_result   [4];
    logic [7:0]   unit_flags_in [4];
    logic         busy          [4];

    int n_checks;
    int n_errors;

    // Stand-in unit: 1.0+2.0 gives 3.0, anything else is an integer sum.
    function automatic logic [31:0] fake_fu(input logic [63:0] ops);
        if (ops == {32'h40000000, 32'h3f800000}) return 32'h40400000;
        return ops[31:0] + ops[63:32];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
        logic [L-1:0][31:0] pipe;

        always_ff @(posedge clk) begin
            pipe[0] <= fake_fu(unit_operands[g]);
            for (int s = 1; s < int'(L); s++) pipe[s] <= pipe[s-1];
        end
        assign unit_result[g]   = pipe[L-1];
        assign unit_flags_in[g] = 8'h5A ^ 8'(g);

        apu_shared_unit_arbiter #(
            .NB_CORES (4),
            .NARGS    (2),
            .WIDTH    (32),
            .WOP      (1),
            .NDSFLAGS (3),
            .NUSFLAGS (8),
            .LATENCY  (L)
        ) u_dut (
            .clk_i           (clk),
            .rst_ni          (rst_n[g]),
            .req_i           (req[g]),
            .gnt_o           (gnt[g]),
            .op_i            (op[g]),
            .operands_i      (operands[g]),
            .flags_i         (flags_in[g]),
            .rvalid_o        (rvalid[g]),
            .result_o        (result[g]),
            .flags_o         (flags_out[g]),
            .unit_en_o       (unit_en[g]),
            .unit_op_o       (unit_op[g]),
            .unit_operands_o (unit_operands[g]),
            .unit_flags_o    (unit_flags[g]),
            .unit_result_i   (unit_result[g]),
            .unit_flags_i    (unit_flags_in[g]),
            .busy_o          (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_inst(input int g);
        rst_n[g] = 1'b0;
        #1;
        rst_n[g] = 1'b1;
    endtask

    logic [3:0] t3_req    [10];
    logic [3:0] t3_gnt    [10];
    logic [3:0] t3_rvalid [10];
    logic       t3_busy   [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        t3_req    = '{4'b1010, 4'b1011, 4'b0011, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        t3_gnt    = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        t3_rvalid = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0};
        t3_busy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int g = 0; g < 4; g++) begin
            rst_n[g]    = 1'b0;
            req[g]      = '0;
            op[g]       = '0;
            operands[g] = '0;
            flags_in[g] = '0;
        end
        #2;
        for (int g = 0; g < 4; g++) begin
            check_eq($sformatf("rst_rvalid%0d", g), 64'(rvalid[g]), 64'h0);
            check_eq($sformatf("rst_busy%0d", g), 64'(busy[g]), 64'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;

        // Single request from core 2: 1.0 + 2.0.
        tick();
        req[0] = 4'b0100;
        op[0] = 4'b0100;
        flags_in[0][6 +: 3] = 3'b101;
        operands[0][128 +: 64] = {32'h40000000, 32'h3f800000};
        #1;
        check_eq("t1_gnt", 64'(gnt[0]), 64'b0100);
        check_eq("t1_en", 64'(unit_en[0]), 64'h1);
        check_eq("t1_rvalid0", 64'(rvalid[0]), 64'h0);
        check_eq("t1_operands", unit_operands[0], {32'h40000000, 32'h3f800000});
        check_eq("t1_op", 64'(unit_op[0]), 64'h1);
        check_eq("t1_flags", 64'(unit_flags[0]), 64'b101);
        tick();
        req[0] = 4'b0;
        #1;
        check_eq("t1_rvalid", 64'(rvalid[0]), 64'b0100);
        check_eq("t1_result", 64'(result[0]), 64'h40400000);
        check_eq("t1_flags_out", 64'(flags_out[0]), 64'h5A);
        check_eq("t1_busy", 64'(busy[0]), 64'h1);
        check_eq("t1_gnt_idle", 64'(gnt[0]), 64'h0);
        tick();
        #1;
        check_eq("t1_busy_end", 64'(busy[0]), 64'h0);
        check_eq("t1_rvalid_end", 64'(rvalid[0]), 64'h0);

        // Full load on all four cores.
        reset_inst(0);
        for (int c = 0; c < 4; c++) operands[0][c*64 +: 64] = {32'h100, 32'(c + 1)};
        for (int i = 0; i < 8; i++) begin
            tick();
            req[0] = 4'hF;
            #1;
            check_eq($sformatf("t2_gnt%0d", i), 64'(gnt[0]), 64'(4'b0001 << (i % 4)));
            if (i == 0) begin
                check_eq("t2_rvalid0", 64'(rvalid[0]), 64'h0);
                check_eq("t2_busy0", 64'(busy[0]), 64'h0);
            end else begin
                check_eq($sformatf("t2_rvalid%0d", i), 64'(rvalid[0]),
                         64'(4'b0001 << ((i - 1) % 4)));
                check_eq($sformatf("t2_result%0d", i), 64'(result[0]),
                         64'(32'h101 + 32'((i - 1) % 4)));
                check_eq($sformatf("t2_busy%0d", i), 64'(busy[0]), 64'h1);
            end
        end

        // Idle: unit inputs hold core 3's last operation despite new core data.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                req[0] = 4'b0;
                operands[0] = {8{32'hDEADBEEF}};
                #1;
                check_eq("t6_last_rvalid", 64'(rvalid[0]), 64'b1000);
            end else begin
                #1;
            end
            check_eq($sformatf("t6_en%0d", i), 64'(unit_en[0]), 64'h0);
            check_eq($sformatf("t6_gnt%0d", i), 64'(gnt[0]), 64'h0);
            check_eq($sformatf("t6_operands%0d", i), unit_operands[0], {32'h100, 32'h4});
        end

        // LATENCY=5 interleaved schedule.
        reset_inst(3);
        for (int i = 0; i < 10; i++) begin
            tick();
            req[3] = t3_req[i];
            #1;
            check_eq($sformatf("t3_gnt%0d", i), 64'(gnt[3]), 64'(t3_gnt[i]));
            check_eq($sformatf("t3_rvalid%0d", i), 64'(rvalid[3]), 64'(t3_rvalid[i]));
            check_eq($sformatf("t3_busy%0d", i), 64'(busy[3]), 64'(t3_busy[i]));
        end

        // LATENCY=3: reset while core 0's operation is in flight.
        reset_inst(2);
        tick();
        req[2] = 4'b0001;
        #1;
        check_eq("t4_gnt", 64'(gnt[2]), 64'b0001);
        tick();
        req[2] = 4'b0;
        #1;
        check_eq("t4_busy_pre", 64'(busy[2]), 64'h1);
        rst_n[2] = 1'b0;
        req[2] = 4'b0100;
        #1;
        check_eq("t4_busy_rst", 64'(busy[2]), 64'h0);
        check_eq("t4_rvalid_rst", 64'(rvalid[2]), 64'h0);
        check_eq("t4_gnt_rst", 64'(gnt[2]), 64'b0100);
        check_eq("t4_en_rst", 64'(unit_en[2]), 64'h1);
        req[2] = 4'b0;
        #1;
        rst_n[2] = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            #1;
            check_eq($sformatf("t4_rvalid%0d", i), 64'(rvalid[2]), 64'h0);
            check_eq($sformatf("t4_busy%0d", i), 64'(busy[2]), 64'h0);
        end

        // LATENCY=2: grant and result to core 3 in the same cycle.
        reset_inst(1);
        for (int i = 0; i < 6; i++) begin
            tick();
            req[1] = 4'b1000;
            #1;
            check_eq($sformatf("t5_gnt%0d", i), 64'(gnt[1]), 64'b1000);
            check_eq($sformatf("t5_rvalid%0d", i), 64'(rvalid[1]),
                     (i >= 2) ? 64'b1000 : 64'h0);
        end
        req[1] = 4'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apu_shared_unit_arbiter.md
# apu_shared_unit_arbiter

Shares one fixed-latency, fully pipelined APU functional unit (FP add/sub, mult, MAC, cast, div or sqrt) among `NB_CORES` core request ports in the APU cluster. Each cycle it grants at most one requester by round-robin and forwards that operation to the unit. It tags every in-flight operation with the issuing core's index and routes the result and flags back to that core exactly `LATENCY` cycles later. There is one instance per shared unit type; private units (`PRIVATE_FP_* = 1`) bypass it.

## Interface
Parameters:
- `NB_CORES`, 4, number of requesting cores (≥2)
- `NARGS`, 2, operands per operation (3 for MAC)
- `WIDTH`, 32, operand/result width (`FP_WIDTH`)
- `WOP`, 1, opcode width (`WOP_*` of the unit)
- `NDSFLAGS`, 3, downstream flag width (`NDSFLAGS_*`)
- `NUSFLAGS`, 8, upstream flag width (`NUSFLAGS_*`)
- `LATENCY`, 1, unit pipeline depth (`C_*_PIPE_REGS`, ≥1)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_i`  in  NB_CORES  per-core request
- `gnt_o`  out  NB_CORES  per-core grant (one-hot or zero)
- `op_i`  in  NB_CORES×WOP  per-core opcode
- `operands_i`  in  NB_CORES×NARGS×WIDTH  per-core operands
- `flags_i`  in  NB_CORES×NDSFLAGS  per-core downstream flags
- `rvalid_o`  out  NB_CORES  per-core result valid (one-hot or zero)
- `result_o`  out  WIDTH  result, broadcast to all cores
- `flags_o`  out  NUSFLAGS  upstream flags, broadcast
- `unit_en_o`  out  1  operation valid into unit
- `unit_op_o` / `unit_operands_o` / `unit_flags_o`  out  WOP / NARGS×WIDTH / NDSFLAGS  muxed operation
- `unit_result_i` / `unit_flags_i`  in  WIDTH / NUSFLAGS  unit output, valid `LATENCY` cycles after `unit_en_o`
- `busy_o`  out  1  any operation in flight

## Operation
- The unit accepts one operation per cycle and never stalls. Cores must accept `rvalid_o` unconditionally.
- Arbitration is combinational within a cycle. The winner is the first requesting index at or after `prio_q`, scanning upward with wrap. `gnt_o[w]=1` and `unit_en_o=1`. The winner's op, operands and flags are muxed onto `unit_*_o`. With no request: `gnt_o=0`, `unit_en_o=0`, and the unit data holds its last value (no toggle).
- Pointer update: on a grant to w, `prio_q ← (w+1) mod NB_CORES`. With no grant it holds.
- Tag pipeline: a `LATENCY`-stage shift register of {valid, id[$clog2(NB_CORES)]}. Stage 0 loads {unit_en_o, w} every cycle. The last stage drives `rvalid_o[id]=valid`.
- `result_o`/`flags_o` pass `unit_result_i`/`unit_flags_i` through combinationally. They are meaningful only when some `rvalid_o` bit is set.
- `busy_o` = OR of all tag valid bits.
- A request must stay asserted with stable data until granted. Deasserting it before the grant is legal and drops the request.

## Timing
- Grant: same cycle as request (0-cycle when the pointer favours it). Worst-case wait is `NB_CORES-1` cycles under full load.
- Result: `rvalid_o` rises exactly `LATENCY` cycles after the grant edge. Back-to-back grants give back-to-back results in issue order.
- Reset (async, any time): `prio_q=0`, all tag valid bits =0. Therefore `rvalid_o=0` and `busy_o=0` immediately. In-flight operations are discarded, and results emerging from the unit after reset are ignored. `gnt_o` and `unit_en_o` follow `req_i` combinationally, also during reset (index 0 first).
- A grant and a result for the same core in the same cycle are independent and both occur.

## Structure
- Widths, latencies, `WOP_*`/`NDSFLAGS_*`/`NUSFLAGS_*` and `PRIVATE_FP_*` stay in the cluster package. The instantiating code selects them per unit.
- Core-id width `$clog2(NB_CORES)` is local.
- One sub-module: `apu_rr_arbiter` (requests, pointer register → one-hot grant, winner index).

## Test plan
- NB_CORES=4, LATENCY=1, only core 2 requests 1.0+2.0 (`32'h3f800000`, `32'h40000000`) → `gnt_o=4'b0100` same cycle, `rvalid_o=4'b0100` next cycle with `result_o=32'h40400000`.
- All four request continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Each `rvalid_o` appears one cycle after its grant, `busy_o` stays high.
- LATENCY=5, cores 1 and 3 request in cycle 0 with cores 0 and 1 in cycle 1 → results arrive in cycles 5, 6 and 7 to cores 1, 3, 0, then core 1 in cycle 8.
- Core 0 granted in cycle 0 (LATENCY=3), `rst_ni` pulsed low in cycle 1 → `rvalid_o` stays 0 through cycle 4 and `busy_o` drops asynchronously.
- Core 3 granted while core 3's earlier result returns (LATENCY=2, continuous core-3 requests) → `gnt_o[3]` and `rvalid_o[3]` both high each cycle.
- No requests for 10 cycles → `unit_en_o=0` and `unit_operands_o` unchanged from the last grant.
